// File: rtl/channel_fifo_rr_stats.sv
// rtl/channel_fifo_rr_stats.sv - per-channel packet FIFO with round-robin channel tagging and stats
//
// Purpose: single-clock packet FIFO between the parser and the matchers. Each dequeued
// packet is tagged with an output channel ID that advances round-robin over NUM_CH on
// every popped EOP, so one stream can be sprayed across NUM_CH engines. Keeps 32-bit
// counters of accepted flits, EOPs and SOPs, plus current and peak occupancy.
//
// Optional feature: define CHFIFO_MAX_FILL_EN to build the peak-occupancy watermark
// register; without it stats_max_fill is tied to zero.
//
// Ports:
//   Clk, Rst_n                     clock, asynchronous active-low reset
//   in_sop/in_eop/in_data/in_empty input flit fields (in_empty meaningful on EOP)
//   in_valid/in_ready              input handshake; in_ready depends only on stored fill
//   in_almost_full                 fill >= DEPTH-AF_MARGIN
//   out_sop/out_eop/out_data/out_empty  output flit fields, held while stalled
//   out_valid/out_ready            output handshake
//   out_channel                    channel ID of the packet at the head
//   stats_flit/stats_pkt/stats_pkt_sop  accepted flit / EOP / SOP counters (wrap)
//   fill_level                     current occupancy, zero-extended
//   stats_max_fill                 highest occupancy since reset (0 without the macro)

module channel_fifo_rr_stats #(
    parameter int DATA_W    = 512,
    parameter int EMPTY_W   = 6,
    parameter int DEPTH     = 512,
    parameter int AF_MARGIN = 16,
    parameter int NUM_CH    = 4,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [EMPTY_W-1:0] in_empty,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               in_almost_full,
    output logic               out_sop,
    output logic               out_eop,
    output logic [DATA_W-1:0]  out_data,
    output logic [EMPTY_W-1:0] out_empty,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH_W-1:0]    out_channel,
    output logic [31:0]        stats_flit,
    output logic [31:0]        stats_pkt,
    output logic [31:0]        stats_pkt_sop,
    output logic [31:0]        fill_level,
    output logic [31:0]        stats_max_fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int MW = DATA_W + EMPTY_W + 2;

    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] rd_word;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_nxt;
    logic          push;
    logic          pop;

    // Handshake flags come only from the registered fill, so there is no
    // combinational path from in_valid to in_ready or to any out_* field.
    assign in_ready       = (fill < FW'(DEPTH));
    assign in_almost_full = (fill >= FW'(DEPTH - AF_MARGIN));
    assign out_valid      = (fill != '0);
    assign push           = in_valid & in_ready;
    assign pop            = out_valid & out_ready;

    always_comb begin
        fill_nxt = fill;
        if (push && !pop) begin
            fill_nxt = fill + 1'b1;
        end else if (pop && !push) begin
            fill_nxt = fill - 1'b1;
        end
    end

    // Storage is not reset: an empty FIFO never exposes its contents.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_sop, in_eop, in_empty, in_data};
        end
    end

    // Head-of-queue read; the head entry cannot be overwritten while it is
    // waiting, so the output fields hold steady during a stall.
    assign rd_word   = mem[rd_ptr];
    assign out_sop   = rd_word[MW-1];
    assign out_eop   = rd_word[MW-2];
    assign out_empty = rd_word[MW-3 -: EMPTY_W];
    assign out_data  = rd_word[DATA_W-1:0];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fill <= fill_nxt;
        end
    end

    assign fill_level = 32'(fill);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stats_flit    <= '0;
            stats_pkt     <= '0;
            stats_pkt_sop <= '0;
        end else if (push) begin
            stats_flit <= stats_flit + 32'd1;
            if (in_eop) begin
                stats_pkt <= stats_pkt + 32'd1;
            end
            if (in_sop) begin
                stats_pkt_sop <= stats_pkt_sop + 32'd1;
            end
        end
    end

    // Channel ID is held for the whole packet and advances once its EOP leaves.
    generate
        if (NUM_CH > 1) begin : g_rr
            logic [CH_W-1:0] ch_r;
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    ch_r <= '0;
                end else if (pop && out_eop) begin
                    ch_r <= (ch_r == CH_W'(NUM_CH - 1)) ? '0 : ch_r + 1'b1;
                end
            end
            assign out_channel = ch_r;
        end else begin : g_single
            assign out_channel = '0;
        end
    endgenerate

`ifdef CHFIFO_MAX_FILL_EN
    // Compared against the next fill so the watermark tracks fill_level
    // in the same cycle rather than one cycle behind.
    logic [31:0] max_fill_r;
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            max_fill_r <= '0;
        end else if (32'(fill_nxt) > max_fill_r) begin
            max_fill_r <= 32'(fill_nxt);
        end
    end
    assign stats_max_fill = max_fill_r;
`else
    assign stats_max_fill = 32'd0;
`endif

endmodule

// File: tb/tb_channel_fifo_rr_stats.sv
// tb/tb_channel_fifo_rr_stats.sv - self-checking bench for channel_fifo_rr_stats
module tb_channel_fifo_rr_stats;

    localparam int DATA_W    = 32;
    localparam int EMPTY_W   = 3;
    localparam int DEPTH     = 16;
    localparam int AF_MARGIN = 4;
    localparam int NUM_CH    = 4;
    localparam int CH_W      = 2;

    logic               Clk = 1'b0;
    logic               Rst_n = 1'b0;
    logic               in_sop = 1'b0;
    logic               in_eop = 1'b0;
    logic [DATA_W-1:0]  in_data = '0;
    logic [EMPTY_W-1:0] in_empty = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_almost_full;
    logic               out_sop;
    logic               out_eop;
    logic [DATA_W-1:0]  out_data;
    logic [EMPTY_W-1:0] out_empty;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [CH_W-1:0]    out_channel;
    logic [31:0]        stats_flit;
    logic [31:0]        stats_pkt;
    logic [31:0]        stats_pkt_sop;
    logic [31:0]        fill_level;
    logic [31:0]        stats_max_fill;

    channel_fifo_rr_stats #(
        .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .DEPTH(DEPTH),
        .AF_MARGIN(AF_MARGIN), .NUM_CH(NUM_CH)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data), .in_empty(in_empty),
        .in_valid(in_valid), .in_ready(in_ready), .in_almost_full(in_almost_full),
        .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data), .out_empty(out_empty),
        .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
        .stats_flit(stats_flit), .stats_pkt(stats_pkt), .stats_pkt_sop(stats_pkt_sop),
        .fill_level(fill_level), .stats_max_fill(stats_max_fill)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic               sop;
        logic               eop;
        logic [DATA_W-1:0]  data;
        logic [EMPTY_W-1:0] empty;
        logic [CH_W-1:0]    ch;
    } flit_t;

    flit_t           sb[$];
    logic [CH_W-1:0] popped_ch[$];
    logic [CH_W-1:0] ch_model = '0;
    logic            acc = 1'b0;
    int              n_checks = 0;
    int              n_fail = 0;
    int              exp_ch[6] = '{0, 1, 2, 3, 0, 1};
    int              exp_max;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard work at the falling edge, return just after the rising edge.
    task automatic tick();
        flit_t e;
        @(negedge Clk);
        acc = 1'b0;
        if (!Rst_n) begin
            sb.delete();
            ch_model = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.data));
                    chk("out_sop", 64'(out_sop), 64'(e.sop));
                    chk("out_eop", 64'(out_eop), 64'(e.eop));
                    chk("out_empty", 64'(out_empty), 64'(e.empty));
                    chk("out_channel", 64'(out_channel), 64'(e.ch));
                end
                popped_ch.push_back(out_channel);
            end
            if (in_valid && in_ready) begin
                acc = 1'b1;
                e.sop = in_sop; e.eop = in_eop; e.data = in_data;
                e.empty = in_empty; e.ch = ch_model;
                sb.push_back(e);
                if (in_eop) ch_model = (ch_model == CH_W'(NUM_CH - 1)) ? '0 : ch_model + 1'b1;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic s, input logic e, input logic [DATA_W-1:0] d,
                        input logic [EMPTY_W-1:0] em);
        in_valid = 1'b1; in_sop = s; in_eop = e; in_data = d; in_empty = em;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0) break;
            tick();
        end
        chk("drain_done", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        // 1: reset values, then one 3-flit packet
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_af", 64'(in_almost_full), 64'd0);
        chk("rst_fill", 64'(fill_level), 64'd0);
        chk("rst_flit", 64'(stats_flit), 64'd0);
        chk("rst_pkt", 64'(stats_pkt), 64'd0);
        chk("rst_sop", 64'(stats_pkt_sop), 64'd0);
        chk("rst_max", 64'(stats_max_fill), 64'd0);
        Rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_data = 32'hA000_0001; in_empty = 3'd0;
        #1;
        chk("no_comb_path", 64'(out_valid), 64'd0);
        send(1'b1, 1'b0, 32'hA000_0001, 3'd0);
        chk("first_latency_valid", 64'(out_valid), 64'd1);
        chk("first_latency_data", 64'(out_data), 64'hA000_0001);
        send(1'b0, 1'b0, 32'hA000_0002, 3'd0);
        send(1'b0, 1'b1, 32'hA000_0003, 3'd5);
        drain();
        tick();
        chk("t1_flit", 64'(stats_flit), 64'd3);
        chk("t1_pkt", 64'(stats_pkt), 64'd1);
        chk("t1_sop", 64'(stats_pkt_sop), 64'd1);
        chk("t1_fill", 64'(fill_level), 64'd0);

        // 2: six single-flit packets round-robin over four channels
        Rst_n = 1'b0; tick(); Rst_n = 1'b1; tick();
        popped_ch.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(1'b1, 1'b1, 32'hB000_0000 + 32'(i), 3'(i));
        drain();
        chk("t2_count", 64'(popped_ch.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < popped_ch.size()) chk("t2_rr_seq", 64'(popped_ch[i]), 64'(exp_ch[i]));
        end

        // 3: fill to DEPTH with the output stalled
        Rst_n = 1'b0; tick(); Rst_n = 1'b1; tick();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send(i == 0, 1'b0, 32'd100 + 32'(i), 3'd0);
            chk("t3_fill", 64'(fill_level), 64'(i + 1));
            chk("t3_af", 64'(in_almost_full), 64'((i + 1) >= DEPTH - AF_MARGIN));
            chk("t3_in_ready", 64'(in_ready), 64'((i + 1) < DEPTH));
        end
        in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b1; in_data = 32'd200; in_empty = 3'd2;
        tick(); tick();
        chk("t3_17th_rejected", 64'(acc), 64'd0);
        chk("t3_full_ready", 64'(in_ready), 64'd0);
        chk("t3_full_fill", 64'(fill_level), 64'd16);
`ifdef CHFIFO_MAX_FILL_EN
        exp_max = 16;
`else
        exp_max = 0;
`endif
        chk("t3_max_fill", 64'(stats_max_fill), 64'(exp_max));

        // 4: one-cycle pop while full, pending flit enters next cycle
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_fill_after_pop", 64'(fill_level), 64'd15);
        chk("t4_ready_after_pop", 64'(in_ready), 64'd1);
        tick();
        chk("t4_pushed", 64'(acc), 64'd1);
        chk("t4_fill_refilled", 64'(fill_level), 64'd16);
        in_valid = 1'b0;

        // 5: stalled head holds its fields
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_valid", 64'(out_valid), 64'd1);
            chk("t5_hold_data", 64'(out_data), 64'(sb[0].data));
            chk("t5_hold_ch", 64'(out_channel), 64'(sb[0].ch));
        end
        drain();
        chk("t5_flit", 64'(stats_flit), 64'd17);
        chk("t5_pkt", 64'(stats_pkt), 64'd1);

        // 6: reset mid-packet
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(i == 0, 1'b0, 32'hC000_0000 + 32'(i), 3'd0);
        chk("t6_fill7", 64'(fill_level), 64'd7);
        Rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_fill", 64'(fill_level), 64'd0);
        chk("t6_rst_flit", 64'(stats_flit), 64'd0);
        chk("t6_rst_pkt", 64'(stats_pkt), 64'd0);
        chk("t6_rst_sop", 64'(stats_pkt_sop), 64'd0);
        chk("t6_rst_max", 64'(stats_max_fill), 64'd0);
        tick();
        Rst_n = 1'b1;
        popped_ch.delete();
        out_ready = 1'b1;
        send(1'b1, 1'b1, 32'hD000_0001, 3'd1);
        drain();
        chk("t6_count", 64'(popped_ch.size()), 64'd1);
        if (popped_ch.size() > 0) chk("t6_ch_after_rst", 64'(popped_ch[0]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
